i2c_req_manager: RTL and testbench

I2C_REQ_MANAGER -- requirements
Module: i2c_req_manager

---
 rtl/i2c_req_manager.sv | 221 ++++++++++++++++++++++
 tb/tb_i2c_req_manager.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_req_manager.sv
// I2C request manager: turns one register-access request into a sequence of
// start / byte / stop requests for the bus-level generators.
//   START, {slave,~we}, reg_addr, N data bytes, STOP  (no repeated start)

package i2c_pkg;
  typedef enum logic [1:0] {
    START = 2'd0,
    BYTE  = 2'd1,
    STOP  = 2'd2
  } t_gen_states;
endpackage

module i2c_req_manager
  import i2c_pkg::*;
#(
  parameter int BURST_WIDTH = 4
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_enable,
  input  logic                   i_valid,
  input  logic                   i_we,
  input  logic                   i_sccb_mode,
  input  logic [6:0]             i_addr_slave,
  input  logic [7:0]             i_addr_reg,
  input  logic [BURST_WIDTH-1:0] i_burst_num,
  output logic                   o_ready,
  input  logic                   i_valid_wr_byte,
  input  logic [7:0]             i_wr_byte,
  output logic                   o_ready_wr_byte,
  output logic [7:0]             o_wr_byte,
  input  logic                   i_byte_ready,
  input  logic                   i_wr_ack,
  input  logic                   i_wr_nack,
  input  logic                   i_rd_valid,
  input  logic                   i_start_stop_done,
  input  logic                   i_start_ready,
  input  logic                   i_stop_ready,
  output t_gen_states            o_active_gen,
  output t_gen_states            o_active_gen_next,
  output logic                   o_req_valid,
  output logic                   o_req_we,
  output logic                   o_req_last_byte
);

  // One extra bit so burst_num = all-ones yields 2^BURST_WIDTH bytes
  localparam int CW = BURST_WIDTH + 1;

  typedef enum logic [2:0] {
    IDLE, START_REQ, START_WAIT, BYTE_LOAD, BYTE_REQ, BYTE_WAIT, STOP_REQ, STOP_WAIT
  } t_state;

  // Which byte of the frame is in flight
  typedef enum logic [1:0] {
    SEL_SLAVE, SEL_REG, SEL_DATA
  } t_sel;

  t_state                 state_reg;
  t_sel                   sel_reg;
  logic [CW-1:0]          data_cnt_reg;
  logic                   we_reg;
  logic                   sccb_reg;
  logic [6:0]             slave_addr_reg;
  logic [7:0]             reg_addr_reg;
  logic [BURST_WIDTH-1:0] burst_reg;

  logic [CW-1:0] total_bytes;
  logic          is_last;
  logic          data_is_rd;
  logic          accept;
  logic          byte_done;
  logic          byte_nack;

  // SCCB always moves a single data byte regardless of burst_num
  assign total_bytes = sccb_reg ? CW'(1) : ({1'b0, burst_reg} + CW'(1));
  assign is_last     = (sel_reg == SEL_DATA) && (data_cnt_reg == total_bytes - CW'(1));
  assign data_is_rd  = (sel_reg == SEL_DATA) && !we_reg;

  // Reset gating keeps o_ready low while the block is held in reset
  assign o_ready   = i_rst && i_enable && (state_reg == IDLE);
  assign accept    = i_valid && o_ready;
  assign byte_nack = (state_reg == BYTE_WAIT) && i_wr_nack;
  assign byte_done = (state_reg == BYTE_WAIT) && !i_wr_nack &&
                     (data_is_rd ? i_rd_valid : i_wr_ack);

  // Next bus owner, derived from the same transitions the FSM takes
  always_comb begin
    o_active_gen_next = o_active_gen;
    if (!i_rst)
      o_active_gen_next = STOP;
    else if (accept)
      o_active_gen_next = START;
    else if ((state_reg == START_WAIT) && i_start_stop_done)
      o_active_gen_next = BYTE;
    else if (byte_nack)
      o_active_gen_next = STOP;
    else if (byte_done)
      o_active_gen_next = is_last ? STOP : BYTE;
  end

  // Main sequencer with registered request outputs
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_reg       <= IDLE;
      sel_reg         <= SEL_SLAVE;
      data_cnt_reg    <= '0;
      we_reg          <= 1'b0;
      sccb_reg        <= 1'b0;
      slave_addr_reg  <= '0;
      reg_addr_reg    <= '0;
      burst_reg       <= '0;
      o_active_gen    <= STOP;
      o_req_valid     <= 1'b0;
      o_ready_wr_byte <= 1'b0;
      o_wr_byte       <= '0;
      o_req_we        <= 1'b0;
      o_req_last_byte <= 1'b0;
    end else begin
      o_active_gen    <= o_active_gen_next;
      o_req_valid     <= 1'b0;
      o_ready_wr_byte <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (accept) begin
            we_reg         <= i_we;
            sccb_reg       <= i_sccb_mode;
            slave_addr_reg <= i_addr_slave;
            reg_addr_reg   <= i_addr_reg;
            burst_reg      <= i_burst_num;
            sel_reg        <= SEL_SLAVE;
            data_cnt_reg   <= '0;
            state_reg      <= START_REQ;
          end
        end
        START_REQ: begin
          if (i_start_ready) begin
            o_req_valid <= 1'b1;
            state_reg   <= START_WAIT;
          end
        end
        START_WAIT: begin
          if (i_start_stop_done) state_reg <= BYTE_LOAD;
        end
        BYTE_LOAD: begin
          case (sel_reg)
            SEL_SLAVE: begin
              o_wr_byte       <= {slave_addr_reg, ~we_reg};
              o_req_we        <= 1'b1;
              o_req_last_byte <= 1'b0;
              state_reg       <= BYTE_REQ;
            end
            SEL_REG: begin
              o_wr_byte       <= reg_addr_reg;
              o_req_we        <= 1'b1;
              o_req_last_byte <= 1'b0;
              state_reg       <= BYTE_REQ;
            end
            default: begin
              if (!we_reg) begin
                // Read: transmit all-ones so the slave can drive SDA
                o_wr_byte       <= 8'hFF;
                o_req_we        <= 1'b0;
                o_req_last_byte <= is_last;
                state_reg       <= BYTE_REQ;
              end else if (i_valid_wr_byte) begin
                o_wr_byte       <= i_wr_byte;
                o_ready_wr_byte <= 1'b1;
                o_req_we        <= 1'b1;
                o_req_last_byte <= is_last;
                state_reg       <= BYTE_REQ;
              end
            end
          endcase
        end
        BYTE_REQ: begin
          if (i_byte_ready) begin
            o_req_valid <= 1'b1;
            state_reg   <= BYTE_WAIT;
          end
        end
        BYTE_WAIT: begin
          if (byte_nack) begin
            o_req_last_byte <= 1'b0;
            state_reg       <= STOP_REQ;
          end else if (byte_done) begin
            o_req_last_byte <= 1'b0;
            case (sel_reg)
              SEL_SLAVE: begin
                sel_reg   <= SEL_REG;
                state_reg <= BYTE_LOAD;
              end
              SEL_REG: begin
                sel_reg   <= SEL_DATA;
                state_reg <= BYTE_LOAD;
              end
              default: begin
                if (is_last) begin
                  state_reg <= STOP_REQ;
                end else begin
                  data_cnt_reg <= data_cnt_reg + CW'(1);
                  state_reg    <= BYTE_LOAD;
                end
              end
            endcase
          end
        end
        STOP_REQ: begin
          if (i_stop_ready) begin
            o_req_valid <= 1'b1;
            state_reg   <= STOP_WAIT;
          end
        end
        STOP_WAIT: begin
          if (i_start_stop_done) state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_req_manager.sv
// Directed bench for i2c_req_manager: an always-ready generator model answers
// every request, a log records each byte request, tests compare the log.

module tb_i2c_req_manager;
  import i2c_pkg::*;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic        i_enable;
  logic        i_valid;
  logic        i_we;
  logic        i_sccb_mode;
  logic [6:0]  i_addr_slave;
  logic [7:0]  i_addr_reg;
  logic [3:0]  i_burst_num;
  logic        o_ready;
  logic        i_valid_wr_byte;
  logic [7:0]  i_wr_byte;
  logic        o_ready_wr_byte;
  logic [7:0]  o_wr_byte;
  logic        i_byte_ready;
  logic        i_wr_ack;
  logic        i_wr_nack;
  logic        i_rd_valid;
  logic        i_start_stop_done;
  logic        i_start_ready;
  logic        i_stop_ready;
  t_gen_states o_active_gen;
  t_gen_states o_active_gen_next;
  logic        o_req_valid;
  logic        o_req_we;
  logic        o_req_last_byte;

  i2c_req_manager #(.BURST_WIDTH(4)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_enable(i_enable), .i_valid(i_valid),
    .i_we(i_we), .i_sccb_mode(i_sccb_mode), .i_addr_slave(i_addr_slave),
    .i_addr_reg(i_addr_reg), .i_burst_num(i_burst_num), .o_ready(o_ready),
    .i_valid_wr_byte(i_valid_wr_byte), .i_wr_byte(i_wr_byte),
    .o_ready_wr_byte(o_ready_wr_byte), .o_wr_byte(o_wr_byte),
    .i_byte_ready(i_byte_ready), .i_wr_ack(i_wr_ack), .i_wr_nack(i_wr_nack),
    .i_rd_valid(i_rd_valid), .i_start_stop_done(i_start_stop_done),
    .i_start_ready(i_start_ready), .i_stop_ready(i_stop_ready),
    .o_active_gen(o_active_gen), .o_active_gen_next(o_active_gen_next),
    .o_req_valid(o_req_valid), .o_req_we(o_req_we), .o_req_last_byte(o_req_last_byte)
  );

  always #5 i_clk = ~i_clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Written by the responder only
  logic [7:0] byte_log[$];
  logic       we_log[$];
  logic       last_log[$];
  logic [1:0] gen_log[$];
  int         req_cnt   = 0;
  int         stops     = 0;
  int         wr_pulses = 0;
  int         ready_err = 0;
  int         txn_byte  = 0;

  // Written by the test sequence only
  int         accepted  = 0;
  int         aborted   = 0;
  int         nack_at   = -1;
  int         wr_base   = 0;
  logic       wr_avail  = 1'b1;
  logic [7:0] wdata [16];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else n_pass++;
  endtask

  // Generator model: answers each request on the following cycle
  initial begin
    i_start_stop_done = 1'b0; i_wr_ack = 1'b0; i_wr_nack = 1'b0; i_rd_valid = 1'b0;
    i_valid_wr_byte = 1'b0; i_wr_byte = 8'h00;
    forever begin
      @(posedge i_clk); #1;
      i_start_stop_done = 1'b0; i_wr_ack = 1'b0; i_wr_nack = 1'b0; i_rd_valid = 1'b0;
      if ((accepted != stops + aborted) && o_ready) ready_err++;
      if (o_ready_wr_byte) wr_pulses++;
      if (o_req_valid) begin
        req_cnt++;
        gen_log.push_back(o_active_gen);
        if (o_active_gen == START) begin
          txn_byte = 0;
          i_start_stop_done = 1'b1;
        end else if (o_active_gen == BYTE) begin
          byte_log.push_back(o_wr_byte);
          we_log.push_back(o_req_we);
          last_log.push_back(o_req_last_byte);
          if (txn_byte == nack_at) i_wr_nack = 1'b1;
          else if (o_req_we)       i_wr_ack  = 1'b1;
          else                     i_rd_valid = 1'b1;
          txn_byte++;
        end else begin
          i_start_stop_done = 1'b1;
          stops++;
        end
      end
      i_valid_wr_byte = wr_avail;
      i_wr_byte = wdata[(wr_pulses - wr_base) % 16];
    end
  end

  task automatic do_req(input logic we, input logic sccb, input logic [6:0] sa,
                        input logic [7:0] ra, input logic [3:0] burst);
    bit ok = 1'b0;
    i_we = we; i_sccb_mode = sccb; i_addr_slave = sa; i_addr_reg = ra;
    i_burst_num = burst; i_valid = 1'b1;
    for (int i = 0; i < 2000 && !ok; i++) begin
      if (o_ready) ok = 1'b1;
      @(posedge i_clk); #1;
    end
    i_valid = 1'b0;
    if (ok) accepted++;
    check("accept", 32'(ok), 32'd1);
    $display("txn we=%0d sccb=%0d slave=%02h reg=%02h burst=%0d", we, sccb, sa, ra, burst);
  endtask

  task automatic wait_txn(input int target);
    for (int i = 0; i < 2000 && stops < target; i++) begin
      @(posedge i_clk); #1;
    end
    check("txn_done", 32'(stops), 32'(target));
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge i_clk); #1;
    end
  endtask

  initial begin
    int b;
    int r;
    int p;
    int s;
    int lastc;
    i_rst = 1'b0; i_enable = 1'b1; i_valid = 1'b0; i_we = 1'b0; i_sccb_mode = 1'b0;
    i_addr_slave = '0; i_addr_reg = '0; i_burst_num = '0;
    i_byte_ready = 1'b1; i_start_ready = 1'b1; i_stop_ready = 1'b1;
    for (int i = 0; i < 16; i++) wdata[i] = 8'h00;
    cycles(3);
    // Reset state
    check("rst_gen", 32'(o_active_gen), 32'(STOP));
    check("rst_gen_next", 32'(o_active_gen_next), 32'(STOP));
    check("rst_ready", 32'(o_ready), 32'd0);
    check("rst_req_valid", 32'(o_req_valid), 32'd0);
    check("rst_wr_byte", 32'(o_wr_byte), 32'd0);
    check("rst_req_we", 32'(o_req_we), 32'd0);
    i_rst = 1'b1;
    cycles(2);

    // Single-byte write
    b = byte_log.size(); r = gen_log.size(); wr_base = wr_pulses; wdata[0] = 8'hCD;
    do_req(1'b1, 1'b0, 7'h7F, 8'h0F, 4'd0);
    wait_txn(1);
    check("t1_nbytes", 32'(byte_log.size() - b), 32'd3);
    check("t1_b0", 32'(byte_log[b]), 32'hFE);
    check("t1_b1", 32'(byte_log[b+1]), 32'h0F);
    check("t1_b2", 32'(byte_log[b+2]), 32'hCD);
    check("t1_last", {29'd0, last_log[b], last_log[b+1], last_log[b+2]}, 32'b001);
    check("t1_gen_first", 32'(gen_log[r]), 32'(START));
    check("t1_gen_end", 32'(gen_log[r+4]), 32'(STOP));
    cycles(2);
    check("t1_gen_hold", 32'(o_active_gen), 32'(STOP));

    // Five-byte write, enable dropped mid-transaction
    b = byte_log.size(); p = wr_pulses; wr_base = wr_pulses;
    for (int i = 0; i < 5; i++) wdata[i] = 8'(8'h11 * (i + 1));
    do_req(1'b1, 1'b0, 7'h50, 8'h10, 4'd4);
    i_enable = 1'b0;
    wait_txn(2);
    check("t2_nbytes", 32'(byte_log.size() - b), 32'd7);
    check("t2_pulses", 32'(wr_pulses - p), 32'd5);
    for (int i = 0; i < 7; i++) begin
      check($sformatf("t2_b%0d", i), 32'(byte_log[b+i]),
            (i == 0) ? 32'hA0 : (i == 1) ? 32'h10 : 32'(8'h11 * (i - 1)));
      check($sformatf("t2_last%0d", i), 32'(last_log[b+i]), 32'(i == 6));
    end
    cycles(2);
    check("t2_ready_disabled", 32'(o_ready), 32'd0);
    i_enable = 1'b1;
    cycles(1);
    check("t2_ready_enabled", 32'(o_ready), 32'd1);

    // Four-byte read
    b = byte_log.size();
    do_req(1'b0, 1'b0, 7'h7F, 8'h0F, 4'd3);
    wait_txn(3);
    check("t3_nbytes", 32'(byte_log.size() - b), 32'd6);
    for (int i = 0; i < 6; i++) begin
      check($sformatf("t3_b%0d", i), 32'(byte_log[b+i]), (i == 1) ? 32'h0F : 32'hFF);
      check($sformatf("t3_we%0d", i), 32'(we_log[b+i]), 32'(i < 2));
      check($sformatf("t3_last%0d", i), 32'(last_log[b+i]), 32'(i == 5));
    end

    // SCCB writes back to back, burst ignored
    b = byte_log.size(); p = wr_pulses; wr_base = wr_pulses;
    for (int i = 0; i < 4; i++) wdata[i] = 8'(8'hC0 + i);
    for (int k = 0; k < 4; k++) do_req(1'b1, 1'b1, 7'h21, 8'(8'h40 + k), 4'd7);
    wait_txn(7);
    check("t4_nbytes", 32'(byte_log.size() - b), 32'd12);
    check("t4_pulses", 32'(wr_pulses - p), 32'd4);
    for (int k = 0; k < 4; k++) begin
      check($sformatf("t4_slv%0d", k), 32'(byte_log[b+3*k]), 32'h42);
      check($sformatf("t4_reg%0d", k), 32'(byte_log[b+3*k+1]), 32'(8'h40 + k));
      check($sformatf("t4_dat%0d", k), 32'(byte_log[b+3*k+2]), 32'(8'hC0 + k));
      check($sformatf("t4_last%0d", k), 32'(last_log[b+3*k+2]), 32'd1);
    end
    check("t4_ready_busy", 32'(ready_err), 32'd0);

    // NACK on slave byte goes straight to stop
    b = byte_log.size(); r = gen_log.size(); p = wr_pulses; nack_at = 0;
    do_req(1'b1, 1'b0, 7'h33, 8'h01, 4'd2);
    wait_txn(8);
    nack_at = -1;
    check("t5_nbytes", 32'(byte_log.size() - b), 32'd1);
    check("t5_nreq", 32'(gen_log.size() - r), 32'd3);
    check("t5_gen_stop", 32'(gen_log[r+2]), 32'(STOP));
    check("t5_pulses", 32'(wr_pulses - p), 32'd0);

    // Write data unavailable: stall before the data byte
    b = byte_log.size(); s = req_cnt; wr_base = wr_pulses; wdata[0] = 8'h5A; wr_avail = 1'b0;
    do_req(1'b1, 1'b0, 7'h10, 8'h20, 4'd0);
    cycles(20);
    check("t6_stall_bytes", 32'(byte_log.size() - b), 32'd2);
    check("t6_stall_reqs", 32'(req_cnt - s), 32'd3);
    wr_avail = 1'b1;
    wait_txn(9);
    check("t6_nbytes", 32'(byte_log.size() - b), 32'd3);
    check("t6_data", 32'(byte_log[b+2]), 32'h5A);

    // Maximum burst: 16 data bytes, no counter wrap
    b = byte_log.size();
    do_req(1'b0, 1'b0, 7'h01, 8'h02, 4'hF);
    wait_txn(10);
    check("t7_nbytes", 32'(byte_log.size() - b), 32'd18);
    lastc = 0;
    for (int i = b; i < byte_log.size(); i++) lastc += int'(last_log[i]);
    check("t7_last_count", 32'(lastc), 32'd1);
    check("t7_last_pos", 32'(last_log[b+17]), 32'd1);

    // Reset mid-transaction abandons it
    do_req(1'b1, 1'b0, 7'h2B, 8'h03, 4'd1);
    cycles(3);
    i_rst = 1'b0; aborted++;
    #1;
    check("t8_gen", 32'(o_active_gen), 32'(STOP));
    check("t8_ready", 32'(o_ready), 32'd0);
    check("t8_req_valid", 32'(o_req_valid), 32'd0);
    check("t8_wr_byte", 32'(o_wr_byte), 32'd0);
    check("t8_req_we", 32'(o_req_we), 32'd0);
    check("t8_last", 32'(o_req_last_byte), 32'd0);
    cycles(2);
    i_rst = 1'b1;
    cycles(1);
    check("t8_ready_after", 32'(o_ready), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
